// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and width helper for the parametrised register file
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    // Address width for a given register count; a one-entry file still gets a 1-bit address.
    function automatic int rf_aw(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - reset-driven clear sequencer, zeroes one entry per clock
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = rf_aw(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          ready
);

    // Entry 0 never needs clearing when it is hardwired to zero.
    localparam logic [AW-1:0] FIRST_IDX = (ZERO_REG != 0) ? AW'(1) : AW'(0);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREG - 1);

    rf_state_t     state;
    rf_state_t     state_next;
    logic [AW-1:0] clr_idx;
    logic [AW-1:0] clr_idx_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RF_CLEAR;
            clr_idx <= FIRST_IDX;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    // The index holds at the last entry on exit so it never wraps.
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        case (state)
            RF_CLEAR: begin
                if (clr_idx == LAST_IDX) begin
                    state_next = RF_READY;
                end else begin
                    clr_idx_next = clr_idx + 1'b1;
                end
            end
            RF_READY: begin
                state_next = RF_READY;
            end
            default: begin
                state_next = RF_CLEAR;
            end
        endcase
    end

    always_comb begin
        clr_we   = (state == RF_CLEAR);
        clr_addr = clr_idx;
        ready    = (state == RF_READY);
    end

endmodule

// File: rtl/regfile_nport_clr.sv
// rtl/regfile_nport_clr.sv - N-read-port register file with optional x0, bypass and sequenced clear
module regfile_nport_clr
    import regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = rf_aw(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       w_addr,
    input  logic [XLEN-1:0]     w_data,
    input  logic [NRD*AW-1:0]   r_addr,
    output logic [NRD*XLEN-1:0] r_data,
    output logic                ready
);

    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            user_we;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem [NREG];

    regfile_clear_seq #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    // A user write only lands in READY, outside reset, and never into a hardwired x0.
    assign user_we = we && ready && !rst && !((ZERO_REG != 0) && (w_addr == '0));

    // Clear and user writes share one port so the array still maps onto block RAM.
    always_comb begin
        mem_we    = clr_we || user_we;
        mem_addr  = clr_we ? clr_addr : w_addr;
        mem_wdata = clr_we ? '0 : w_data;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_lane
        logic [AW-1:0]   addr_k;
        logic [XLEN-1:0] data_k;

        assign addr_k = r_addr[k*AW +: AW];

        always_comb begin
            data_k = mem[addr_k];
            if (!ready) begin
                data_k = '0;
            end else if ((ZERO_REG != 0) && (addr_k == '0)) begin
                data_k = '0;
            end else if ((BYPASS != 0) && user_we && (w_addr == addr_k)) begin
                data_k = w_data;
            end
        end

        assign r_data[k*XLEN +: XLEN] = data_k;
    end

endmodule
